// File: rtl/button_events.sv
// ----------------------------------------------------------------------------
// button_events
//
// Turns per-button debounced value/strobe pairs into discrete UI events
// (PRESS, RELEASE, LONG, REPEAT). Each button has a small FSM with a 32-bit
// hold down-counter. Every (button, kind) pair owns one pending bit. A single
// output register presents one event at a time on a valid/ready interface.
//
// Ports:
//   clk       system clock (only clock domain)
//   rst_n     asynchronous active-low reset
//   val       debounced button levels; only looked at when strb[i]=1
//   strb      1-cycle pulse per button: val[i] is freshly stable
//   ev_valid  an event is presented
//   ev_ready  consumer accepts the event when ev_valid && ev_ready
//   ev_btn    button index of the presented event
//   ev_kind   0=PRESS 1=RELEASE 2=LONG 3=REPEAT
//   ev_drop   1-cycle pulse: an event hit an already-full pending slot
// ----------------------------------------------------------------------------
module button_events #(
    parameter int BUTTONS     = 4,
    parameter int ACTIVE_LOW  = 1,
    parameter int LONG_TIME   = 50_000_000,
    parameter int REPEAT_TIME = 10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BUTTONS-1:0] val,
    input  logic [BUTTONS-1:0] strb,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [2:0]         ev_btn,
    output logic [1:0]         ev_kind,
    output logic               ev_drop
);

    localparam int          NPEND        = 4 * BUTTONS;
    localparam logic [31:0] LONG_LOAD    = 32'(LONG_TIME - 1);
    localparam logic [31:0] REPEAT_LOAD  = 32'(REPEAT_TIME - 1);
    // Level of val that means "pressed".
    localparam logic        PRESS_LEVEL  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    localparam logic [1:0]  KIND_PRESS   = 2'd0;
    localparam logic [1:0]  KIND_RELEASE = 2'd1;
    localparam logic [1:0]  KIND_LONG    = 2'd2;
    localparam logic [1:0]  KIND_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    // Within one button, presentation order is PRESS, LONG, REPEAT, RELEASE.
    // RELEASE goes last so a quick tap always reads PRESS before RELEASE.
    function automatic logic [1:0] prio_kind(input int j);
        case (j)
            0:       prio_kind = KIND_PRESS;
            1:       prio_kind = KIND_LONG;
            2:       prio_kind = KIND_REPEAT;
            default: prio_kind = KIND_RELEASE;
        endcase
    endfunction

    // Event requests from all button FSMs, 4 bits per button indexed by kind.
    logic [NPEND-1:0] set_vec;

    // ------------------------------------------------------------------
    // Per-button FSMs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BUTTONS; gi++) begin : g_btn
            state_t      state_reg;
            state_t      state_next;
            logic [31:0] cnt_reg;
            logic [31:0] cnt_next;
            logic [3:0]  set_bits;
            logic        press;
            logic        rel;

            assign press = strb[gi] & (val[gi] == PRESS_LEVEL);
            assign rel   = strb[gi] & (val[gi] != PRESS_LEVEL);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_UP;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                set_bits   = '0;
                case (state_reg)
                    ST_UP: begin
                        // A release strobe while already up is ignored.
                        if (press) begin
                            set_bits[KIND_PRESS] = 1'b1;
                            cnt_next             = LONG_LOAD;
                            state_next           = ST_DOWN;
                        end
                    end
                    ST_DOWN: begin
                        // Release beats an expiring counter on the same cycle.
                        if (rel) begin
                            set_bits[KIND_RELEASE] = 1'b1;
                            state_next             = ST_UP;
                        end else if (cnt_reg == 32'd0) begin
                            set_bits[KIND_LONG] = 1'b1;
                            cnt_next            = REPEAT_LOAD;
                            state_next          = ST_HELD;
                        end else begin
                            cnt_next = cnt_reg - 32'd1;
                        end
                    end
                    ST_HELD: begin
                        if (rel) begin
                            set_bits[KIND_RELEASE] = 1'b1;
                            state_next             = ST_UP;
                        end else if (cnt_reg == 32'd0) begin
                            set_bits[KIND_REPEAT] = 1'b1;
                            cnt_next              = REPEAT_LOAD;
                        end else begin
                            cnt_next = cnt_reg - 32'd1;
                        end
                    end
                    default: begin
                        state_next = ST_UP;
                    end
                endcase
            end

            assign set_vec[4*gi +: 4] = set_bits;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pending store and output register
    // ------------------------------------------------------------------
    logic [NPEND-1:0] pend_reg;
    logic [NPEND-1:0] pend_next;
    logic [NPEND-1:0] clear_vec;
    logic             ev_valid_reg;
    logic [2:0]       ev_btn_reg;
    logic [1:0]       ev_kind_reg;
    logic             ev_drop_reg;
    logic             drop_next;
    logic             found;
    logic             load;
    logic [2:0]       sel_btn;
    logic [1:0]       sel_kind;
    int               sel_idx;

    // Priority pick: scan from the lowest-priority slot upwards so the
    // last hit (lowest button, earliest kind in order) wins.
    always_comb begin
        found    = 1'b0;
        sel_btn  = '0;
        sel_kind = '0;
        sel_idx  = 0;
        for (int b = BUTTONS - 1; b >= 0; b--) begin
            for (int j = 3; j >= 0; j--) begin
                if (pend_reg[4*b + int'(prio_kind(j))]) begin
                    found    = 1'b1;
                    sel_btn  = 3'(b);
                    sel_kind = prio_kind(j);
                    sel_idx  = 4*b + int'(prio_kind(j));
                end
            end
        end
    end

    always_comb begin
        load      = found && (!ev_valid_reg || ev_ready);
        clear_vec = '0;
        if (load) begin
            clear_vec[sel_idx] = 1'b1;
        end
        // A slot being emptied on this edge can take a new event without loss.
        drop_next = |(set_vec & pend_reg & ~clear_vec);
        pend_next = (pend_reg & ~clear_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg     <= '0;
            ev_valid_reg <= 1'b0;
            ev_btn_reg   <= '0;
            ev_kind_reg  <= '0;
            ev_drop_reg  <= 1'b0;
        end else begin
            pend_reg    <= pend_next;
            ev_drop_reg <= drop_next;
            // Output only advances when empty or being accepted, which keeps
            // btn/kind stable while the consumer stalls.
            if (!ev_valid_reg || ev_ready) begin
                ev_valid_reg <= found;
                if (found) begin
                    ev_btn_reg  <= sel_btn;
                    ev_kind_reg <= sel_kind;
                end
            end
        end
    end

    assign ev_valid = ev_valid_reg;
    assign ev_btn   = ev_btn_reg;
    assign ev_kind  = ev_kind_reg;
    assign ev_drop  = ev_drop_reg;

endmodule

// File: tb/tb_button_events.sv
// ----------------------------------------------------------------------------
// tb_button_events
//
// Self-checking bench for button_events (BUTTONS=4, ACTIVE_LOW=1,
// LONG_TIME=20, REPEAT_TIME=5). Expected events are pushed to a scoreboard
// queue when stimulus is driven; a negedge monitor pops and compares them as
// the DUT hands events over, and also checks output stability under stall
// and the ev_drop pulse.
// ----------------------------------------------------------------------------
module tb_button_events;

    localparam int LT = 20;
    localparam int RT = 5;

    localparam logic [1:0] K_PRESS   = 2'd0;
    localparam logic [1:0] K_RELEASE = 2'd1;
    localparam logic [1:0] K_LONG    = 2'd2;
    localparam logic [1:0] K_REPEAT  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] val = 4'hF;
    logic [3:0] strb = 4'h0;
    logic       ev_ready = 1'b1;
    logic       ev_valid;
    logic [2:0] ev_btn;
    logic [1:0] ev_kind;
    logic       ev_drop;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int ready_mode = 0;      // 0: ready=1, 1: ready=0, 2: random
    int drop_edge = -100;    // edge count at which ev_drop is expected high
    logic mon_en = 1'b0;

    typedef struct {
        logic [2:0] b;
        logic [1:0] k;
        int         e;       // expected edge count when seen valid; -1 = any
    } exp_t;
    exp_t sb[$];
    exp_t cur;

    typedef struct {
        int              gap;
        logic [3:0]      s;
        logic [3:0]      v;
        int              n;
        logic [3:0][2:0] eb;
        logic [3:0][1:0] ek;
    } vec_t;
    vec_t tbl[9];

    button_events #(
        .BUTTONS    (4),
        .ACTIVE_LOW (1),
        .LONG_TIME  (LT),
        .REPEAT_TIME(RT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .val     (val),
        .strb    (strb),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_btn  (ev_btn),
        .ev_kind (ev_kind),
        .ev_drop (ev_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ev_ready = 1'b1;
            1:       ev_ready = 1'b0;
            default: ev_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push(input logic [2:0] b, input logic [1:0] k, input int e);
        exp_t x;
        x.b = b;
        x.k = k;
        x.e = e;
        sb.push_back(x);
    endtask

    // One-cycle strobe; smp is the edge count of the sampling edge.
    task automatic pulse(input logic [3:0] s, input logic [3:0] v, output int smp);
        @(posedge clk);
        #1;
        smp  = edge_n + 1;
        strb = s;
        val  = v;
        @(posedge clk);
        #1;
        strb = 4'h0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    function automatic vec_t mk(input int gap, input logic [3:0] s, input logic [3:0] v,
                                input int n, input logic [3:0][2:0] eb,
                                input logic [3:0][1:0] ek);
        vec_t r;
        r.gap = gap; r.s = s; r.v = v; r.n = n; r.eb = eb; r.ek = ek;
        return r;
    endfunction

    // Monitor: handshake compare, stall stability, drop pulse.
    logic       hold_prev = 1'b0;
    logic [2:0] prev_b = '0;
    logic [1:0] prev_k = '0;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("stall_valid", 32'(ev_valid), 32'd1);
                chk("stall_btn", 32'(ev_btn), 32'(prev_b));
                chk("stall_kind", 32'(ev_kind), 32'(prev_k));
            end
            chk("ev_drop", 32'(ev_drop), (edge_n == drop_edge) ? 32'd1 : 32'd0);
            if (ev_valid && ev_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got btn=%0d kind=%0d expected none (edge %0d)",
                             ev_btn, ev_kind, edge_n);
                end else begin
                    cur = sb.pop_front();
                    chk("ev_btn", 32'(ev_btn), 32'(cur.b));
                    chk("ev_kind", 32'(ev_kind), 32'(cur.k));
                    if (cur.e >= 0) chk("ev_time", 32'(edge_n), 32'(cur.e));
                end
            end
            hold_prev = ev_valid && !ev_ready;
            prev_b    = ev_btn;
            prev_k    = ev_kind;
        end
    end

    initial begin
        int s;
        int s0;
        int b;
        logic [3:0] m;

        // Taps, simultaneous presses/releases, ignored duplicate strobes.
        tbl[0] = mk(5, 4'b0010, 4'b1101, 1, {3'd0, 3'd0, 3'd0, 3'd1}, {K_PRESS, K_PRESS, K_PRESS, K_PRESS});
        tbl[1] = mk(4, 4'b0010, 4'b1111, 1, {3'd0, 3'd0, 3'd0, 3'd1}, {K_PRESS, K_PRESS, K_PRESS, K_RELEASE});
        tbl[2] = mk(3, 4'b0010, 4'b1111, 0, {3'd0, 3'd0, 3'd0, 3'd0}, {K_PRESS, K_PRESS, K_PRESS, K_PRESS});
        tbl[3] = mk(3, 4'b1111, 4'b0000, 4, {3'd3, 3'd2, 3'd1, 3'd0}, {K_PRESS, K_PRESS, K_PRESS, K_PRESS});
        tbl[4] = mk(5, 4'b0101, 4'b0000, 0, {3'd0, 3'd0, 3'd0, 3'd0}, {K_PRESS, K_PRESS, K_PRESS, K_PRESS});
        tbl[5] = mk(3, 4'b1111, 4'b1111, 4, {3'd3, 3'd2, 3'd1, 3'd0}, {K_RELEASE, K_RELEASE, K_RELEASE, K_RELEASE});
        tbl[6] = mk(3, 4'b0011, 4'b1110, 1, {3'd0, 3'd0, 3'd0, 3'd0}, {K_PRESS, K_PRESS, K_PRESS, K_PRESS});
        tbl[7] = mk(3, 4'b1001, 4'b0111, 2, {3'd0, 3'd0, 3'd3, 3'd0}, {K_PRESS, K_PRESS, K_PRESS, K_RELEASE});
        tbl[8] = mk(3, 4'b1000, 4'b1111, 1, {3'd0, 3'd0, 3'd0, 3'd3}, {K_PRESS, K_PRESS, K_PRESS, K_RELEASE});

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_btn", 32'(ev_btn), 32'd0);
        chk("rst_kind", 32'(ev_kind), 32'd0);
        chk("rst_drop", 32'(ev_drop), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Table-driven vectors, ready held high: event j at sample edge + 1 + j
        for (int i = 0; i < 9; i++) begin
            repeat (tbl[i].gap) @(posedge clk);
            pulse(tbl[i].s, tbl[i].v, s);
            for (int j = 0; j < tbl[i].n; j++) push(tbl[i].eb[j], tbl[i].ek[j], s + 1 + j);
        end
        drain(20);

        // Stalled consumer: PRESS, RELEASE, PRESS, RELEASE on button 2.
        // First PRESS sits on the output, second PRESS fills its slot again,
        // second RELEASE finds the RELEASE slot full and is dropped.
        ready_mode = 1;
        repeat (2) @(posedge clk);
        pulse(4'b0100, 4'b1011, s);
        repeat (2) @(posedge clk);
        pulse(4'b0100, 4'b1111, s);
        repeat (2) @(posedge clk);
        pulse(4'b0100, 4'b1011, s);
        repeat (2) @(posedge clk);
        pulse(4'b0100, 4'b1111, s);
        drop_edge = s;
        push(3'd2, K_PRESS, -1);
        push(3'd2, K_PRESS, -1);
        push(3'd2, K_RELEASE, -1);
        repeat (4) @(posedge clk);
        ready_mode = 0;
        drain(50);
        drop_edge = -100;

        // Random ready: single taps, one at a time
        ready_mode = 2;
        for (int i = 0; i < 8; i++) begin
            b = int'($urandom_range(0, 3));
            m = 4'(1 << b);
            pulse(m, ~m, s);
            push(3'(b), K_PRESS, -1);
            repeat (2) @(posedge clk);
            pulse(m, 4'hF, s);
            push(3'(b), K_RELEASE, -1);
            drain(200);
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);

        // Long hold on button 0: LONG, REPEATs, release coinciding with a
        // REPEAT expiry wins and no REPEAT follows.
        pulse(4'b0001, 4'b1110, s0);
        push(3'd0, K_PRESS, s0 + 1);
        push(3'd0, K_LONG, s0 + LT + 1);
        push(3'd0, K_REPEAT, s0 + LT + RT + 1);
        push(3'd0, K_REPEAT, s0 + LT + 2*RT + 1);
        push(3'd0, K_REPEAT, s0 + LT + 3*RT + 1);
        repeat (38) @(posedge clk);
        pulse(4'b0001, 4'b1111, s);
        chk("release_edge", 32'(s), 32'(s0 + 40));
        push(3'd0, K_RELEASE, s + 1);
        repeat (15) @(posedge clk);
        drain(10);

        // Reset during HELD: hold state is lost until a new press strobe
        pulse(4'b0010, 4'b1101, s0);
        push(3'd1, K_PRESS, s0 + 1);
        push(3'd1, K_LONG, s0 + LT + 1);
        push(3'd1, K_REPEAT, s0 + LT + RT + 1);
        repeat (27) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", 32'(ev_valid), 32'd0);
        chk("midrst_btn", 32'(ev_btn), 32'd0);
        chk("midrst_kind", 32'(ev_kind), 32'd0);
        chk("midrst_left", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        pulse(4'b0010, 4'b1101, s);
        push(3'd1, K_PRESS, s + 1);
        repeat (3) @(posedge clk);
        pulse(4'b0010, 4'b1111, s);
        push(3'd1, K_RELEASE, s + 1);
        drain(10);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
